// File: rtl/lc3_mem_access_seq_if.sv
// Handshake and datapath-control bundle between the LC-3 memory-access sequencer and the ISDU/datapath.
// MEM_READY_EN adds the Mem_Ready wait-extension input.
interface lc3_mem_access_seq_if;
  logic       Start;
  logic [3:0] Opcode;
`ifdef MEM_READY_EN
  logic       Mem_Ready;
`endif
  logic       ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic       GateMARMUX;
  logic       GateMDR;
  logic       GateSR;
  logic       LD_MAR;
  logic       LD_MDR;
  logic       MIO_EN;
  logic       LD_REG;
  logic       Mem_OE;
  logic       Mem_WE;
  logic       Busy;
  logic       Done;
  logic       Illegal;

  // Start is a request: it is only taken when Busy=0, and Done or Illegal pulses mark the end of that request.
  modport master (
    input  Start, Opcode,
`ifdef MEM_READY_EN
    input  Mem_Ready,
`endif
    output ADDR1MUX, ADDR2MUX, GateMARMUX, GateMDR, GateSR, LD_MAR, LD_MDR,
           MIO_EN, LD_REG, Mem_OE, Mem_WE, Busy, Done, Illegal
  );

  modport slave (
    output Start, Opcode,
`ifdef MEM_READY_EN
    output Mem_Ready,
`endif
    input  ADDR1MUX, ADDR2MUX, GateMARMUX, GateMDR, GateSR, LD_MAR, LD_MDR,
           MIO_EN, LD_REG, Mem_OE, Mem_WE, Busy, Done, Illegal
  );
endinterface

// File: rtl/lc3_mem_access_seq.sv
// Sequences LC-3 LD/LDI/LDR/ST/STI/STR through the address adder, MAR/MDR and SRAM strobes.
// Optional build macro MEM_READY_EN: SRAM strobes also wait for Mem_Ready after MEM_WAIT cycles.
module lc3_mem_access_seq #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  lc3_mem_access_seq_if.master  bus,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD, S_IND, S_SD, S_WR, S_WB, S_DONE
  } state_e;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       store_q, store_d;
  logic       indir_q, indir_d;
  logic       pass2_q, pass2_d;
  logic       illegal_q, illegal_d;
  logic       addr1_q, addr1_d;
  logic [1:0] addr2_q, addr2_d;
  logic       legal;
  logic       ready;
  logic       strobe_last;

`ifdef MEM_READY_EN
  assign ready = bus.Mem_Ready;
`else
  assign ready = 1'b1;
`endif

  // Counter saturates at the last wait cycle so Mem_Ready can stretch the strobe indefinitely.
  assign strobe_last = (cnt_q >= WAIT_LAST) && ready;

  always_comb begin
    legal = 1'b0;
    case (bus.Opcode)
      4'b0010, 4'b0011, 4'b1010, 4'b1011, 4'b0110, 4'b0111: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      store_q   <= 1'b0;
      indir_q   <= 1'b0;
      pass2_q   <= 1'b0;
      illegal_q <= 1'b0;
      addr1_q   <= 1'b0;
      addr2_q   <= 2'b11;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      store_q   <= store_d;
      indir_q   <= indir_d;
      pass2_q   <= pass2_d;
      illegal_q <= illegal_d;
      addr1_q   <= addr1_d;
      addr2_q   <= addr2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = 4'd0;
    store_d   = store_q;
    indir_d   = indir_q;
    pass2_d   = pass2_q;
    illegal_d = 1'b0;
    addr1_d   = addr1_q;
    addr2_d   = addr2_q;
    case (state_q)
      S_IDLE: begin
        pass2_d = 1'b0;
        if (bus.Start) begin
          if (legal) begin
            state_d = S_ADDR;
            store_d = bus.Opcode[0];
            indir_d = bus.Opcode[3];
            addr1_d = ~bus.Opcode[2];
            addr2_d = bus.Opcode[2] ? 2'b10 : 2'b01;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_ADDR: state_d = (store_q && !indir_q) ? S_SD : S_RD;
      S_RD: begin
        if (strobe_last) begin
          state_d = (indir_q && !pass2_q) ? S_IND : S_WB;
        end else begin
          cnt_d = (cnt_q >= WAIT_LAST) ? cnt_q : cnt_q + 4'd1;
        end
      end
      S_IND: begin
        pass2_d = 1'b1;
        state_d = store_q ? S_SD : S_RD;
      end
      S_SD: state_d = S_WR;
      S_WR: begin
        if (strobe_last) begin
          state_d = S_DONE;
        end else begin
          cnt_d = (cnt_q >= WAIT_LAST) ? cnt_q : cnt_q + 4'd1;
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.GateMARMUX = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateSR     = 1'b0;
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.MIO_EN     = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;
    bus.Done       = 1'b0;
    case (state_q)
      S_ADDR: begin
        bus.GateMARMUX = 1'b1;
        bus.LD_MAR     = 1'b1;
      end
      S_RD: begin
        bus.Mem_OE = 1'b0;
        bus.MIO_EN = 1'b1;
        bus.LD_MDR = strobe_last;
      end
      S_IND: begin
        bus.GateMDR = 1'b1;
        bus.LD_MAR  = 1'b1;
      end
      S_SD: begin
        bus.GateSR = 1'b1;
        bus.LD_MDR = 1'b1;
      end
      S_WR: bus.Mem_WE = 1'b0;
      S_WB: begin
        bus.GateMDR = 1'b1;
        bus.LD_REG  = 1'b1;
      end
      S_DONE:  bus.Done = 1'b1;
      default: ;
    endcase
  end

  assign bus.ADDR1MUX = addr1_q;
  assign bus.ADDR2MUX = addr2_q;
  assign bus.Busy     = (state_q != S_IDLE);
  assign bus.Illegal  = illegal_q;
  assign dbg_state_o  = state_q;

endmodule
